// File: rtl/reg_file_access_pkg.sv
// Shared FSM state encoding and read-latency limits for the register-file access master.
package reg_file_access_pkg;

  localparam logic [2:0] LP_ST_IDLE    = 3'd0;
  localparam logic [2:0] LP_ST_WRITE   = 3'd1;
  localparam logic [2:0] LP_ST_READ    = 3'd2;
  localparam logic [2:0] LP_ST_WAIT    = 3'd3;
  localparam logic [2:0] LP_ST_RESPOND = 3'd4;

  localparam int LP_MAX_READ_LATENCY = 7;
  localparam int LP_LAT_W            = $clog2(LP_MAX_READ_LATENCY + 1);
  localparam logic [LP_LAT_W-1:0] LP_LAT_ONE = LP_LAT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = LP_ST_IDLE,
    S_WRITE   = LP_ST_WRITE,
    S_READ    = LP_ST_READ,
    S_WAIT    = LP_ST_WAIT,
    S_RESPOND = LP_ST_RESPOND
  } state_t;

endpackage

// File: rtl/read_latency_counter.sv
// Down-counter timing the target read latency; done is high while the count is zero.
// Load wins over decrement; decrement saturates at zero.
module read_latency_counter
  import reg_file_access_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic                i_dec,
  input  logic [LP_LAT_W-1:0] i_value,
  output logic                o_done
);

  logic [LP_LAT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - LP_LAT_ONE;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/reg_file_access_master.sv
// Single-outstanding command master driving one-cycle read/write strobes into a register file.
// Response latency: error 1, write 2, read 2+P_ReadLatency; response held until In_RspReady.
module reg_file_access_master
  import reg_file_access_pkg::*;
#(
  parameter int P_RegCount    = 3,
  parameter int P_BitWidth    = 32,
  parameter int P_ReadLatency = 1,
  localparam int AW           = $clog2(P_RegCount)
) (
  input  logic                  In_Clock,
  input  logic                  In_Reset,
  input  logic                  In_CmdValid,
  output logic                  Out_CmdReady,
  input  logic                  In_CmdWrite,
  input  logic [AW-1:0]         In_CmdAddress,
  input  logic [P_BitWidth-1:0] In_CmdData,
  output logic                  Out_RspValid,
  input  logic                  In_RspReady,
  output logic [P_BitWidth-1:0] Out_RspData,
  output logic                  Out_RspError,
  output logic [AW-1:0]         Out_Address,
  output logic [P_BitWidth-1:0] Out_WriteData,
  output logic                  Out_Write,
  output logic                  Out_Read,
  input  logic [P_BitWidth-1:0] In_ReadData
);

  localparam logic [AW:0] LP_REG_COUNT = (AW + 1)'(P_RegCount);
  localparam logic [LP_LAT_W-1:0] LP_WAIT_LOAD =
    (P_ReadLatency > 0) ? LP_LAT_W'(P_ReadLatency - 1) : '0;

  state_t                r_state;
  logic                  r_write;
  logic                  r_read;
  logic                  r_rsp_vld;
  logic                  r_rsp_err;
  logic [P_BitWidth-1:0] r_rsp_data;
  logic [AW-1:0]         r_addr;
  logic [P_BitWidth-1:0] r_wdata;

  logic w_addr_err;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_done;

  assign w_addr_err = ({1'b0, In_CmdAddress} >= LP_REG_COUNT);
  assign w_cnt_load = (r_state == S_READ);
  assign w_cnt_dec  = (r_state == S_WAIT);

  read_latency_counter u_lat_cnt (
    .i_clk   (In_Clock),
    .i_rst   (In_Reset),
    .i_load  (w_cnt_load),
    .i_dec   (w_cnt_dec),
    .i_value (LP_WAIT_LOAD),
    .o_done  (w_cnt_done)
  );

  always_ff @(posedge In_Clock or posedge In_Reset) begin
    if (In_Reset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (In_CmdValid) begin
            r_addr  <= In_CmdAddress;
            r_wdata <= In_CmdData;
            if (w_addr_err) begin
              r_rsp_vld  <= 1'b1;
              r_rsp_err  <= 1'b1;
              r_rsp_data <= '0;
              r_state    <= S_RESPOND;
            end else if (In_CmdWrite) begin
              r_write <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_read  <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          r_rsp_vld  <= 1'b1;
          r_rsp_err  <= 1'b0;
          r_rsp_data <= '0;
          r_state    <= S_RESPOND;
        end
        S_READ: begin
          if (P_ReadLatency == 0) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= In_ReadData;
            r_state    <= S_RESPOND;
          end else begin
            r_state <= S_WAIT;
          end
        end
        // The counter was loaded with latency-1 on entry, so done marks the last wait cycle.
        S_WAIT: begin
          if (w_cnt_done) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= In_ReadData;
            r_state    <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (In_RspReady) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Out_CmdReady  = (r_state == S_IDLE) && !In_Reset;
  assign Out_RspValid  = r_rsp_vld;
  assign Out_RspData   = r_rsp_data;
  assign Out_RspError  = r_rsp_err;
  assign Out_Address   = r_addr;
  assign Out_WriteData = r_wdata;
  assign Out_Write     = r_write;
  assign Out_Read      = r_read;

endmodule

// File: doc/reg_file_access_master.md
REG_FILE_ACCESS_MASTER -- requirements
Module: reg_file_access_master

Interface
REQ-001 SHALL have one clock, In_Clock; reset In_Reset is asynchronous and active-high.
REQ-002 SHALL have parameter P_RegCount, default 3, number of target registers (legal >= 2).
REQ-003 SHALL have parameter P_BitWidth, default 32, data width.
REQ-004 SHALL have parameter P_ReadLatency, default 1, target read latency in cycles (legal 0..7).
REQ-005 SHALL define AW = $clog2(P_RegCount) as the address width.
REQ-006 In_Clock  in  1  rising-edge clock.
REQ-007 In_Reset  in  1  async active-high reset.
REQ-008 In_CmdValid  in  1  command offered.
REQ-009 Out_CmdReady  out  1  command accepted this cycle when high with In_CmdValid.
REQ-010 In_CmdWrite  in  1  1 = write, 0 = read.
REQ-011 In_CmdAddress  in  AW  target register index.
REQ-012 In_CmdData  in  P_BitWidth  write data.
REQ-013 Out_RspValid  out  1  response available.
REQ-014 In_RspReady  in  1  response consumed when high with Out_RspValid.
REQ-015 Out_RspData  out  P_BitWidth  read data (0 for writes and errors).
REQ-016 Out_RspError  out  1  address >= P_RegCount.
REQ-017 Out_Address  out  AW  register-file address.
REQ-018 Out_WriteData  out  P_BitWidth  register-file write data.
REQ-019 Out_Write  out  1  one-cycle write strobe.
REQ-020 Out_Read  out  1  one-cycle read strobe.
REQ-021 In_ReadData  in  P_BitWidth  register-file read data.

Function
REQ-022 SHALL implement FSM states IDLE, WRITE, READ, WAIT, RESPOND, with at most one transaction outstanding.
REQ-023 IDLE: Out_CmdReady=1; on In_CmdValid, capture address, data and direction.
REQ-024 IDLE transitions on accept: illegal address -> RESPOND (Out_RspError=1, data 0, no strobe); write -> WRITE; read -> READ.
REQ-025 Out_CmdReady SHALL be 0 in every state except IDLE.
REQ-026 WRITE: Out_Write=1 for exactly one cycle with the captured address and data, then -> RESPOND with Out_RspError=0 and Out_RspData=0.
REQ-027 READ: Out_Read=1 for exactly one cycle (cycle T); with P_ReadLatency=0, sample In_ReadData at the edge ending T and go to RESPOND.
REQ-028 READ with P_ReadLatency>0: go to WAIT and count P_ReadLatency cycles; sample In_ReadData at the edge ending cycle T+P_ReadLatency, then -> RESPOND.
REQ-029 RESPOND: Out_RspValid=1, with Out_RspData and Out_RspError held stable until In_RspReady=1; then -> IDLE on the same edge.
REQ-030 Latency from the accept edge to Out_RspValid rising: write 2 cycles; read 2+P_ReadLatency cycles; error 1 cycle.
REQ-031 Out_Write and Out_Read SHALL never both be high, and SHALL be 0 outside WRITE and READ respectively.
REQ-032 Out_Address and Out_WriteData SHALL hold the last captured values between transactions.
REQ-033 A new command SHALL NOT be accepted on the same edge as the response handshake; the earliest accept is the following cycle in IDLE.
REQ-034 Address compare SHALL be unsigned; for P_RegCount a power of two, Out_RspError is never set.

Reset
REQ-035 While In_Reset=1: state IDLE, all outputs 0 except Out_CmdReady, latency counter and captured registers 0.
REQ-036 Out_CmdReady SHALL be 1 only after In_Reset deasserts (0 while reset is asserted).
REQ-037 Reset mid-transaction SHALL abort it immediately: strobes drop asynchronously and no response is produced.

Structure
REQ-038 Shared package reg_file_access_pkg SHALL hold the state encoding localparams and the maximum-latency constant (7).
REQ-039 The WAIT countdown SHALL be a sub-module read_latency_counter (load, decrement, done flag, 3-bit width).

Verification (P_RegCount=3, P_BitWidth=32, P_ReadLatency=1)
REQ-040 Write addr 2, data 0xDEADBEEF -> Out_Write high one cycle with Out_Address=2 and Out_WriteData=0xDEADBEEF; Out_RspValid 2 cycles after accept with Out_RspError=0.
REQ-041 Read addr 2, target returns 0xDEADBEEF one cycle after Out_Read -> Out_RspData=0xDEADBEEF, Out_RspValid 3 cycles after accept.
REQ-042 Read addr 3 -> Out_RspError=1 and Out_RspData=0 one cycle after accept; Out_Read/Out_Write never asserted.
REQ-043 Hold In_RspReady=0 for 5 cycles during RESPOND -> response stable, Out_CmdReady=0, second command not accepted until the cycle after the handshake.
REQ-044 Assert In_Reset during WAIT -> strobes 0, no Out_RspValid; after release, a read of addr 0 completes normally.
REQ-045 Back-to-back write then read of addr 1 (0x12345678) with In_RspReady tied high -> read returns 0x12345678; Out_Write and Out_Read never overlap.
